forwarding_scoreboard_unit: RTL and testbench

Parametrised operand-forwarding and hazard unit for the Grande-Risco-5 pipeline. For every ID/EX read port it selects the operand source (register file, MEM/WB, EX/MEM ALU result, EX/MEM load data) and drives the operand value. It raises a stall for load-use hazards and for registers owned by an in-flight long-latency unit (mul/div); those registers are tracked in a register scoreboard. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_port_select.sv | 55 +++++
 rtl/forwarding_scoreboard_unit.sv | 114 +++++++++++
 tb/tb_forwarding_scoreboard_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and default widths for the operand-forwarding and hazard unit.
// Ports: none. This file only holds the forwarding source code enum and the
// default parameter values that the unit and its per-port selector use.
package fwd_pkg;

  // Operand source codes. The encoding is visible on the fwd_sel output.
  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10,
    FWD_LOAD   = 2'b11
  } fwd_sel_t;

  localparam int DEF_NUM_READ_PORTS = 2;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_XLEN           = 32;
  localparam int DEF_CNT_WIDTH      = 32;

endpackage

// File: rtl/fwd_port_select.sv
// Per-read-port forwarding selector.
// Ports:
//   rs / rf_data                     - source index and its register-file value
//   ex_mem_rd/we/is_load/result      - EX/MEM destination info and ALU result
//   load_data / load_data_valid      - memory read data for the EX/MEM load
//   mem_wb_rd/we/result              - MEM/WB destination info and value
//   sel                              - chosen source code
//   operand                          - chosen operand value
//   load_hazard                      - port depends on a load whose data is not ready
module fwd_port_select
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int XLEN           = DEF_XLEN
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd,
  input  logic                      ex_mem_we,
  input  logic                      ex_mem_is_load,
  input  logic [XLEN-1:0]           ex_mem_result,
  input  logic [XLEN-1:0]           load_data,
  input  logic                      load_data_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd,
  input  logic                      mem_wb_we,
  input  logic [XLEN-1:0]           mem_wb_result,
  output fwd_sel_t                  sel,
  output logic [XLEN-1:0]           operand,
  output logic                      load_hazard
);

  // The youngest producer wins: EX/MEM before MEM/WB before the register file.
  // Register 0 is hardwired to zero, so it never forwards and reads as 0.
  always_comb begin
    sel     = FWD_RF;
    operand = rf_data;
    if (rs == '0) begin
      operand = '0;
    end else if (ex_mem_we && (ex_mem_rd == rs)) begin
      if (ex_mem_is_load) begin
        sel     = FWD_LOAD;
        operand = load_data;
      end else begin
        sel     = FWD_EX_MEM;
        operand = ex_mem_result;
      end
    end else if (mem_wb_we && (mem_wb_rd == rs)) begin
      sel     = FWD_MEM_WB;
      operand = mem_wb_result;
    end
  end

  assign load_hazard = (sel == FWD_LOAD) && !load_data_valid;

endmodule

// File: rtl/forwarding_scoreboard_unit.sv
// Operand forwarding, hazard detection and long-latency register scoreboard.
// Ports:
//   clk, rst_n                     - clock and synchronous active-low reset
//   id_valid                       - instruction in ID/EX is valid
//   rs, rf_data                    - per-port source indices and register-file data
//   ex_mem_*, load_data*, mem_wb_* - forwarding sources from later stages
//   lat_issue/_rd, lat_done/_rd    - long-latency unit ownership begin/end
//   stall_clear                    - zeroes the stall counter
//   fwd_sel, operand               - per-port source code and selected value
//   stall                          - hold IF/ID/EX this cycle
//   stall_cycles                   - saturating count of stalled cycles
module forwarding_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int XLEN           = DEF_XLEN,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          id_valid,
  input  logic [NUM_READ_PORTS-1:0][REG_ADDR_WIDTH-1:0] rs,
  input  logic [NUM_READ_PORTS-1:0][XLEN-1:0]           rf_data,
  input  logic [REG_ADDR_WIDTH-1:0]                     ex_mem_rd,
  input  logic                                          ex_mem_we,
  input  logic                                          ex_mem_is_load,
  input  logic [XLEN-1:0]                               ex_mem_result,
  input  logic [XLEN-1:0]                               load_data,
  input  logic                                          load_data_valid,
  input  logic [REG_ADDR_WIDTH-1:0]                     mem_wb_rd,
  input  logic                                          mem_wb_we,
  input  logic [XLEN-1:0]                               mem_wb_result,
  input  logic                                          lat_issue,
  input  logic [REG_ADDR_WIDTH-1:0]                     lat_issue_rd,
  input  logic                                          lat_done,
  input  logic [REG_ADDR_WIDTH-1:0]                     lat_done_rd,
  input  logic                                          stall_clear,
  output logic [NUM_READ_PORTS-1:0][1:0]                fwd_sel,
  output logic [NUM_READ_PORTS-1:0][XLEN-1:0]           operand,
  output logic                                          stall,
  output logic [CNT_WIDTH-1:0]                          stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [NUM_REGS-1:0]       busy;
  logic [NUM_REGS-1:0]       busy_next;
  logic [NUM_READ_PORTS-1:0] load_hz;
  logic [NUM_READ_PORTS-1:0] sb_hz;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_port
    fwd_sel_t port_sel;

    fwd_port_select #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
      .XLEN          (XLEN)
    ) u_sel (
      .rs             (rs[p]),
      .rf_data        (rf_data[p]),
      .ex_mem_rd      (ex_mem_rd),
      .ex_mem_we      (ex_mem_we),
      .ex_mem_is_load (ex_mem_is_load),
      .ex_mem_result  (ex_mem_result),
      .load_data      (load_data),
      .load_data_valid(load_data_valid),
      .mem_wb_rd      (mem_wb_rd),
      .mem_wb_we      (mem_wb_we),
      .mem_wb_result  (mem_wb_result),
      .sel            (port_sel),
      .operand        (operand[p]),
      .load_hazard    (load_hz[p])
    );

    assign fwd_sel[p] = port_sel;
    assign sb_hz[p]   = (rs[p] != '0) && busy[rs[p]];
  end

  assign stall = id_valid && ((|load_hz) || (|sb_hz));

  // Done is applied before issue so a same-cycle issue/done on one register
  // leaves it owned by the newly issued operation.
  always_comb begin
    busy_next = busy;
    if (lat_done) begin
      busy_next[lat_done_rd] = 1'b0;
    end
    if (lat_issue && (lat_issue_rd != '0)) begin
      busy_next[lat_issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register. Reset drops all in-flight ownership.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Stall counter: clear beats increment, and the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_clear) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard_unit.sv
// Self-checking bench for forwarding_scoreboard_unit: directed scenarios
// followed by randomized traffic, compared against a behavioural model that
// tracks register ownership as a set and the stall count as an integer.
module tb_forwarding_scoreboard_unit;

  localparam int NP      = 2;
  localparam int AW      = 5;
  localparam int XW      = 32;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                   clk;
  logic                   rst_n;
  logic                   id_valid;
  logic [NP-1:0][AW-1:0]  rs;
  logic [NP-1:0][XW-1:0]  rf_data;
  logic [AW-1:0]          ex_mem_rd;
  logic                   ex_mem_we;
  logic                   ex_mem_is_load;
  logic [XW-1:0]          ex_mem_result;
  logic [XW-1:0]          load_data;
  logic                   load_data_valid;
  logic [AW-1:0]          mem_wb_rd;
  logic                   mem_wb_we;
  logic [XW-1:0]          mem_wb_result;
  logic                   lat_issue;
  logic [AW-1:0]          lat_issue_rd;
  logic                   lat_done;
  logic [AW-1:0]          lat_done_rd;
  logic                   stall_clear;
  logic [NP-1:0][1:0]     fwd_sel;
  logic [NP-1:0][XW-1:0]  operand;
  logic                   stall;
  logic [CW-1:0]          stall_cycles;

  int num_checks = 0;
  int num_fails  = 0;

  // Reference state: the set of registers owned by long-latency ops, and the count.
  bit owned[int];
  int cnt_m = 0;

  forwarding_scoreboard_unit #(
    .NUM_READ_PORTS(NP),
    .REG_ADDR_WIDTH(AW),
    .XLEN          (XW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .rs             (rs),
    .rf_data        (rf_data),
    .ex_mem_rd      (ex_mem_rd),
    .ex_mem_we      (ex_mem_we),
    .ex_mem_is_load (ex_mem_is_load),
    .ex_mem_result  (ex_mem_result),
    .load_data      (load_data),
    .load_data_valid(load_data_valid),
    .mem_wb_rd      (mem_wb_rd),
    .mem_wb_we      (mem_wb_we),
    .mem_wb_result  (mem_wb_result),
    .lat_issue      (lat_issue),
    .lat_issue_rd   (lat_issue_rd),
    .lat_done       (lat_done),
    .lat_done_rd    (lat_done_rd),
    .stall_clear    (stall_clear),
    .fwd_sel        (fwd_sel),
    .operand        (operand),
    .stall          (stall),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source choice for one port, straight from the priority rules.
  task automatic modelPort(input int p, output int sel, output logic [XW-1:0] val);
    int r;
    r = int'(rs[p]);
    if (r == 0) begin
      sel = 0; val = '0;
    end else if (ex_mem_we && int'(ex_mem_rd) == r) begin
      sel = ex_mem_is_load ? 3 : 2;
      val = ex_mem_is_load ? load_data : ex_mem_result;
    end else if (mem_wb_we && int'(mem_wb_rd) == r) begin
      sel = 1; val = mem_wb_result;
    end else begin
      sel = 0; val = rf_data[p];
    end
  endtask

  // Check all outputs for the current inputs, then advance one clock and
  // update the model with what the edge should have done.
  task automatic applyStimulus();
    int              sel;
    logic [XW-1:0]   val;
    bit              exp_stall;
    exp_stall = 1'b0;
    #1;
    for (int p = 0; p < NP; p++) begin
      modelPort(p, sel, val);
      if (id_valid && sel == 3 && !load_data_valid) exp_stall = 1'b1;
      if (id_valid && rs[p] != '0 && owned.exists(int'(rs[p]))) exp_stall = 1'b1;
      checkOutput($sformatf("fwd_sel%0d", p), 64'(fwd_sel[p]), 64'(sel));
    end
    checkOutput("stall", 64'(stall), 64'(exp_stall));
    if (!exp_stall) begin
      for (int p = 0; p < NP; p++) begin
        modelPort(p, sel, val);
        checkOutput($sformatf("operand%0d", p), 64'(operand[p]), 64'(val));
      end
    end
    checkOutput("stall_cycles", 64'(stall_cycles), 64'(cnt_m));
    @(posedge clk);
    if (!rst_n) begin
      owned.delete();
      cnt_m = 0;
    end else begin
      if (lat_done && owned.exists(int'(lat_done_rd))) owned.delete(int'(lat_done_rd));
      if (lat_issue && lat_issue_rd != '0) owned[int'(lat_issue_rd)] = 1'b1;
      if (stall_clear) cnt_m = 0;
      else if (exp_stall && cnt_m < CNT_MAX) cnt_m++;
    end
    #1;
  endtask

  task automatic setIdle();
    rst_n = 1'b1; id_valid = 1'b0; rs = '0;
    rf_data[0] = $urandom; rf_data[1] = $urandom;
    ex_mem_rd = '0; ex_mem_we = 1'b0; ex_mem_is_load = 1'b0; ex_mem_result = $urandom;
    load_data = $urandom; load_data_valid = 1'b0;
    mem_wb_rd = '0; mem_wb_we = 1'b0; mem_wb_result = $urandom;
    lat_issue = 1'b0; lat_issue_rd = '0; lat_done = 1'b0; lat_done_rd = '0;
    stall_clear = 1'b0;
  endtask

  task automatic randomizeInputs();
    rst_n           = ($urandom_range(0, 59) != 0);
    id_valid        = ($urandom_range(0, 7) != 0);
    rs[0]           = AW'($urandom_range(0, 7));
    rs[1]           = AW'($urandom_range(0, 7));
    rf_data[0]      = $urandom;
    rf_data[1]      = $urandom;
    ex_mem_rd       = AW'($urandom_range(0, 7));
    ex_mem_we       = 1'($urandom);
    ex_mem_is_load  = 1'($urandom);
    ex_mem_result   = $urandom;
    load_data       = $urandom;
    load_data_valid = 1'($urandom);
    mem_wb_rd       = AW'($urandom_range(0, 7));
    mem_wb_we       = 1'($urandom);
    mem_wb_result   = $urandom;
    lat_issue       = ($urandom_range(0, 5) == 0);
    lat_issue_rd    = AW'($urandom_range(0, 7));
    lat_done        = ($urandom_range(0, 2) == 0);
    lat_done_rd     = AW'($urandom_range(0, 7));
    stall_clear     = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    int base;
    setIdle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("reset_count", 64'(stall_cycles), 64'd0);

    // EX/MEM ALU hit beats a MEM/WB hit on the same register.
    id_valid = 1'b1; rs[0] = 5'd5; ex_mem_rd = 5'd5; ex_mem_we = 1'b1;
    mem_wb_rd = 5'd5; mem_wb_we = 1'b1; ex_mem_result = 32'hCAFE_0005;
    #1;
    checkOutput("tp_exmem_sel", 64'(fwd_sel[0]), 64'd2);
    checkOutput("tp_exmem_op", 64'(operand[0]), 64'hCAFE_0005);
    applyStimulus();

    // Register 0 never forwards and reads as zero.
    setIdle();
    id_valid = 1'b1; rs[1] = '0; ex_mem_rd = '0; ex_mem_we = 1'b1; ex_mem_result = 32'hDEAD;
    #1;
    checkOutput("tp_x0_sel", 64'(fwd_sel[1]), 64'd0);
    checkOutput("tp_x0_op", 64'(operand[1]), 64'd0);
    applyStimulus();

    // Load-use: stall until load data is valid, then forward it.
    setIdle();
    id_valid = 1'b1; rs[0] = 5'd7; ex_mem_rd = 5'd7; ex_mem_we = 1'b1; ex_mem_is_load = 1'b1;
    #1;
    checkOutput("tp_lu_stall", 64'(stall), 64'd1);
    checkOutput("tp_lu_sel", 64'(fwd_sel[0]), 64'd3);
    applyStimulus();
    load_data_valid = 1'b1; load_data = 32'h1234;
    #1;
    checkOutput("tp_lu_release", 64'(stall), 64'd0);
    checkOutput("tp_lu_op", 64'(operand[0]), 64'h1234);
    applyStimulus();

    // Long-latency ownership of x9 stalls a reader until the cycle after done.
    setIdle();
    base = cnt_m;
    id_valid = 1'b1; rs[1] = 5'd9; lat_issue = 1'b1; lat_issue_rd = 5'd9;
    applyStimulus();
    lat_issue = 1'b0;
    repeat (3) applyStimulus();
    lat_done = 1'b1; lat_done_rd = 5'd9;
    applyStimulus();
    lat_done = 1'b0;
    #1;
    checkOutput("tp_sb_release", 64'(stall), 64'd0);
    checkOutput("tp_sb_count", 64'(int'(stall_cycles) - base), 64'd4);
    applyStimulus();

    // Same-cycle issue and done on x3 leaves it busy; issue to x0 is ignored.
    setIdle();
    lat_issue = 1'b1; lat_issue_rd = 5'd3; lat_done = 1'b1; lat_done_rd = 5'd3;
    applyStimulus();
    setIdle();
    id_valid = 1'b1; rs[0] = 5'd3;
    #1;
    checkOutput("tp_same_busy", 64'(stall), 64'd1);
    lat_done = 1'b1; lat_done_rd = 5'd3; lat_issue = 1'b1; lat_issue_rd = '0;
    applyStimulus();
    setIdle();
    id_valid = 1'b1; rs[0] = 5'd3;
    applyStimulus();

    // Saturation, clear-over-increment, then reset in the middle of a stall.
    setIdle();
    lat_issue = 1'b1; lat_issue_rd = 5'd4; stall_clear = 1'b1;
    applyStimulus();
    setIdle();
    id_valid = 1'b1; rs[0] = 5'd4;
    repeat (CNT_MAX + 5) applyStimulus();
    checkOutput("tp_saturate", 64'(stall_cycles), 64'(CNT_MAX));
    stall_clear = 1'b1;
    applyStimulus();
    checkOutput("tp_clear_prio", 64'(stall_cycles), 64'd0);
    stall_clear = 1'b0;
    repeat (2) applyStimulus();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    #1;
    checkOutput("tp_rst_busy", 64'(stall), 64'd0);
    checkOutput("tp_rst_count", 64'(stall_cycles), 64'd0);
    applyStimulus();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      randomizeInputs();
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
